// File: rtl/fp_norm_round.sv
// Normalise-and-round stage for the binary32 adder: a one-bit-per-cycle
// normaliser followed by round-to-nearest-even and IEEE-754 packing.
module fp_norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic        sign_q;
  logic [8:0]  exp_q;
  logic [27:0] mant_q;
  logic [31:0] result_q;
  logic [3:0]  flags_q;

  // Rounding and packing operate on the fully normalised mantissa in ROUND.
  logic        up, inexact;
  logic [24:0] m25;
  logic [23:0] m24;
  logic [8:0]  exp_rnd;
  logic [31:0] pack_result;
  logic [3:0]  pack_flags;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pack_result = 32'h0;
    pack_flags  = 4'h0;
    inexact     = mant_q[2] | mant_q[1] | mant_q[0];
    up          = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    m25         = {1'b0, mant_q[26:3]} + {24'd0, up};
    m24         = m25[24] ? m25[24:1] : m25[23:0];
    exp_rnd     = exp_q + {8'd0, m25[24]};
    if (exp_rnd >= 9'd255) begin
      pack_result = {sign_q, 8'hFF, 23'h0};
      pack_flags  = 4'b1010;
    end else if (!m24[23]) begin
      pack_result = {sign_q, 8'h00, m24[22:0]};
      pack_flags  = {1'b0, inexact && (m24 != 24'd0), inexact, m24 == 24'd0};
    end else begin
      pack_result = {sign_q, exp_rnd[7:0], m24[22:0]};
      pack_flags  = {2'b00, inexact, 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = NORM;
      NORM: begin
        if (mant_q == 28'd0)                   state_nxt = DONE;
        else if (mant_q[27])                   state_nxt = ROUND;
        else if (!mant_q[26] && exp_q > 9'd1)  state_nxt = NORM;
        else                                   state_nxt = ROUND;
      end
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q   <= 1'b0;
      exp_q    <= 9'd0;
      mant_q   <= 28'd0;
      result_q <= 32'h0;
      flags_q  <= 4'h0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q <= in_sign;
          exp_q  <= {1'b0, in_exp};
          mant_q <= in_mant;
        end
        NORM: begin
          if (mant_q == 28'd0) begin
            result_q <= {sign_q, 31'h0};
            flags_q  <= 4'b0001;
          end else if (mant_q[27]) begin
            // The bit shifted out folds into sticky so rounding stays exact.
            mant_q <= {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + 9'd1;
          end else if (!mant_q[26] && exp_q > 9'd1) begin
            mant_q <= {mant_q[26:0], 1'b0};
            exp_q  <= exp_q - 9'd1;
          end
        end
        ROUND: begin
          result_q <= pack_result;
          flags_q  <= pack_flags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: result words, flags, latency, handshake
// stalls, back-to-back throughput and reset abort.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'h0;
  logic [27:0] in_mant = 28'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  fp_norm_round dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs [14] = '{
    '{"norm_13p75",     1'b0, 8'h82, {1'b0, 1'b1, 23'h5C0000, 3'b000}, 32'h415C0000, 4'b0000, 3},
    '{"neg_13p75",      1'b1, 8'h82, {1'b0, 1'b1, 23'h5C0000, 3'b000}, 32'hC15C0000, 4'b0000, 3},
    '{"carry_3p0",      1'b0, 8'h7F, {1'b1, 1'b1, 23'h000000, 3'b000}, 32'h40400000, 4'b0000, 3},
    '{"cancel_23",      1'b0, 8'h82, 28'h0000008,                      32'h35800000, 4'b0000, 26},
    '{"cancel_25",      1'b0, 8'h82, 28'h0000002,                      32'h34800000, 4'b0000, 28},
    '{"rne_carry_out",  1'b0, 8'h7F, {1'b0, 1'b1, 23'h7FFFFF, 3'b100}, 32'h40000000, 4'b0010, 3},
    '{"rne_tie_even",   1'b0, 8'h7F, {1'b0, 1'b1, 23'h000000, 3'b100}, 32'h3F800000, 4'b0010, 3},
    '{"rne_tie_odd",    1'b0, 8'h7F, {1'b0, 1'b1, 23'h000001, 3'b100}, 32'h3F800002, 4'b0010, 3},
    '{"rne_above_half", 1'b0, 8'h7F, {1'b0, 1'b1, 23'h000000, 3'b101}, 32'h3F800001, 4'b0010, 3},
    '{"overflow",       1'b0, 8'hFE, {1'b1, 1'b0, 23'h000000, 3'b000}, 32'h7F800000, 4'b1010, 3},
    '{"subnorm_exact",  1'b0, 8'h01, {1'b0, 1'b0, 23'h400000, 3'b000}, 32'h00400000, 4'b0000, 3},
    '{"subnorm_inexact",1'b0, 8'h01, {1'b0, 1'b0, 23'h000001, 3'b010}, 32'h00000001, 4'b0110, 3},
    '{"subnorm_to_norm",1'b0, 8'h01, {1'b0, 1'b0, 23'h7FFFFF, 3'b110}, 32'h00800000, 4'b0010, 3},
    '{"zero_neg",       1'b1, 8'h05, 28'h0000000,                      32'h80000000, 4'b0001, 2}
  };

  // Called at a negedge. Latency is the accept edge to the first edge that
  // samples out_valid high; -1 when out_valid never rises.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                        output logic [31:0] res, output logic [3:0] flg,
                        output int lat);
    int k;
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    lat = out_valid ? k + 1 : -1;
    res = out_result;
    flg = out_flags;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++;
    if (out_result !== 32'h0) begin failed++; $display("FAIL reset_out_result: got %h want 00000000", out_result); end
    tests++;
    if (out_flags !== 4'h0) begin failed++; $display("FAIL reset_out_flags: got %b want 0000", out_flags); end
  endtask

  task automatic test_vectors();
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    foreach (vecs[i]) begin
      run_op(vecs[i].sign, vecs[i].exp, vecs[i].mant, res, flg, lat);
      tests++;
      if (res !== vecs[i].res) begin
        failed++; $display("FAIL %s result: got %h want %h", vecs[i].name, res, vecs[i].res);
      end
      tests++;
      if (flg !== vecs[i].flg) begin
        failed++; $display("FAIL %s flags: got %b want %b", vecs[i].name, flg, vecs[i].flg);
      end
      tests++;
      if (lat !== vecs[i].lat) begin
        failed++; $display("FAIL %s latency: got %0d want %0d", vecs[i].name, lat, vecs[i].lat);
      end
    end
  endtask

  // in_valid stays high across both operands; the second one must wait in
  // IDLE-return and be accepted exactly latency+1 cycles after the first.
  task automatic test_back_to_back();
    int k, acc1, acc2;
    logic [31:0] res_a, res_b;
    in_sign = 1'b0; in_exp = 8'h7F; in_mant = {1'b1, 1'b1, 23'h0, 3'b000}; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk);
    acc1 = cyc;
    @(negedge clk);
    in_sign = 1'b1; in_exp = 8'h82; in_mant = {1'b0, 1'b1, 23'h5C0000, 3'b000};
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    res_a = out_result;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk);
    acc2 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    res_b = out_result;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (res_a !== 32'h40400000) begin failed++; $display("FAIL b2b_first: got %h want 40400000", res_a); end
    tests++;
    if (res_b !== 32'hC15C0000) begin failed++; $display("FAIL b2b_second: got %h want C15C0000", res_b); end
    tests++;
    if (acc2 - acc1 !== 4) begin failed++; $display("FAIL b2b_spacing: got %0d want 4", acc2 - acc1); end
  endtask

  task automatic test_stall();
    int k;
    out_ready = 1'b0;
    in_sign = 1'b1; in_exp = 8'h82; in_mant = {1'b0, 1'b1, 23'h5C0000, 3'b000}; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'hC15C0000 || out_flags !== 4'b0000) begin
        failed++;
        $display("FAIL stall_cycle%0d: got valid=%b ready=%b res=%h flags=%b want 1 0 C15C0000 0000",
                 c, out_valid, in_ready, out_result, out_flags);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++; $display("FAIL stall_release: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int k;
    bit seen;
    in_sign = 1'b0; in_exp = 8'h82; in_mant = 28'h0000008; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++; $display("FAIL abort_state: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    tests++;
    if (out_result !== 32'h0 || out_flags !== 4'h0) begin
      failed++; $display("FAIL abort_outputs: got res=%h flags=%b want 00000000 0000", out_result, out_flags);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin failed++; $display("FAIL abort_no_output: got out_valid=1 want never"); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
